// File: rtl/load_store_unit.sv
// RV32I load/store unit: one load or store per start over a req/gnt/rvalid bus; busy stalls the core.
// Define BUS_TIMEOUT_EN to fault an access after TIMEOUT_CYCLES without gnt or rvalid.
module load_store_unit #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] rdata_out,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic [2:0]       funct3_q;
  logic             store_q, fault_q;
  logic             dec_fault;
  logic             timeout;
  logic [3:0]       be_w;
  logic [WIDTH-1:0] wdata_w;
  logic [15:0]      lane;
  logic [WIDTH-1:0] load_ext;

  // Decode on the raw inputs so a bad access can go straight to DONE.
  always_comb begin
    dec_fault = 1'b0;
    case (funct3)
      3'b000:  dec_fault = 1'b0;
      3'b001:  dec_fault = addr[0];
      3'b010:  dec_fault = |addr[1:0];
      3'b100:  dec_fault = is_store;
      3'b101:  dec_fault = is_store | addr[0];
      default: dec_fault = 1'b1;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == REQ || state == RESP) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout = (state == REQ || state == RESP) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    be_w    = 4'b1111;
    wdata_w = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_w    = 4'b0001 << addr_q[1:0];
        wdata_w = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_w    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_w = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = 16'(mem_rdata >> {addr_q[1:0], 3'b000});

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    fault     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = dec_fault ? DONE : REQ;
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
        mem_be    = be_w;
        mem_wdata = wdata_w;
        if (mem_gnt)      state_nxt = store_q ? DONE : RESP;
        else if (timeout) state_nxt = DONE;
      end
      RESP: begin
        if (mem_rvalid || timeout) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        fault     = fault_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= 3'b000;
      store_q   <= 1'b0;
      fault_q   <= 1'b0;
      rdata_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            store_q  <= is_store;
            fault_q  <= dec_fault;
          end
        end
        REQ: begin
          if (!mem_gnt && timeout) fault_q <= 1'b1;
        end
        RESP: begin
          // rvalid in the limit cycle wins over the timeout.
          if (mem_rvalid)   rdata_out <= load_ext;
          else if (timeout) fault_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
